// File: rtl/data_loader_pkg.sv
// Shared types and constants for the training-data loader controller.
// The data widths describe the 10.10 fixed-point x/y samples selected by cnt.
package data_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } dl_state_t;

    localparam int DL_NUM_SAMPLES = 150;
    localparam int DL_CNT_W       = 8;
    localparam int DL_DATA_W      = 20;
    localparam int DL_FRAC_W      = 10;
    localparam int DL_EPOCH_W     = 8;

endpackage

// File: rtl/dl_mod_counter.sv
// Modulo-N counter: clr has priority over inc, and wrap flags the increment
// that takes the count from N-1 back to 0.
module dl_mod_counter
    import data_loader_pkg::*;
#(
    parameter int N = DL_NUM_SAMPLES,
    parameter int W = DL_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/data_loader_ctrl.sv
// Epoch/sample sequencer for the training-data loader: streams sample indices
// to the compute unit and holds an acknowledged update phase between epochs.
module data_loader_ctrl
    import data_loader_pkg::*;
#(
    parameter int NUM_SAMPLES = DL_NUM_SAMPLES,
    parameter int CNT_W       = DL_CNT_W,
    parameter int EPOCH_W     = DL_EPOCH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [EPOCH_W-1:0] num_epochs,
    input  logic               abort,
    output logic [CNT_W-1:0]   cnt,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               sample_last,
    output logic               epoch_end,
    input  logic               upd_ack,
    output logic [EPOCH_W-1:0] epoch,
    output logic               busy,
    output logic               done,
    output dl_state_t          state_dbg
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    dl_state_t          state_q, state_d;
    logic [EPOCH_W-1:0] epoch_q;
    logic [EPOCH_W-1:0] epoch_lim_q;
    logic               accept_start;
    logic               xfer;
    logic               cnt_wrap;
    logic               final_epoch;

    // Handshake: a sample moves on any cycle where sample_valid && sample_ready
    // are both high at the rising edge; valid never depends on ready, and cnt
    // (hence x/y) stays put while valid is high and ready is low.
    assign accept_start = (state_q == IDLE) && start;
    assign xfer         = (state_q == STREAM) && sample_ready;
    assign final_epoch  = (epoch_q == epoch_lim_q - 1'b1);

    dl_mod_counter #(
        .N (NUM_SAMPLES),
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (abort | accept_start),
        .inc   (xfer),
        .count (cnt),
        .wrap  (cnt_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)    state_d = STREAM;
                STREAM:  if (cnt_wrap) state_d = UPDATE;
                UPDATE:  if (upd_ack)  state_d = final_epoch ? DONE : STREAM;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A requested epoch count of zero runs a single epoch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epoch_q     <= '0;
            epoch_lim_q <= EPOCH_W'(1);
        end else if (!abort) begin
            if (accept_start) begin
                epoch_q     <= '0;
                epoch_lim_q <= (num_epochs == '0) ? EPOCH_W'(1) : num_epochs;
            end else if ((state_q == UPDATE) && upd_ack && !final_epoch) begin
                epoch_q <= epoch_q + 1'b1;
            end
        end
    end

    assign sample_valid = (state_q == STREAM);
    assign sample_last  = (state_q == STREAM) && (cnt == LAST_IDX);
    assign epoch_end    = (state_q == UPDATE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign epoch        = epoch_q;
    assign state_dbg    = state_q;

endmodule
